// File: rtl/mmm_pkg.sv
// Shared front-end types and constants for the i-cache request path.
package mmm_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_IC_REQ   = 2;
  localparam int IC_REQ_IDX_W = 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            fault;
  } icache_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } icache_arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational grant: round-robin on last_i, or fixed priority to
// requester 0 when ICACHE_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter_2 (
  input  logic [1:0] req_valid_i,
`ifndef ICACHE_ARB_FIXED_PRIO_EN
  input  logic       last_i,
`endif
  output logic [1:0] grant_o,
  output logic       grant_idx_o,
  output logic       grant_any_o
);

  always_comb begin
    grant_any_o = |req_valid_i;
`ifdef ICACHE_ARB_FIXED_PRIO_EN
    grant_idx_o = ~req_valid_i[0];
`else
    // Under contention the requester that did not win last time goes next.
    if (&req_valid_i) grant_idx_o = ~last_i;
    else              grant_idx_o = req_valid_i[1];
`endif
    grant_o = 2'b00;
    if (grant_any_o) grant_o = grant_idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/icache_arbiter.sv
// Shares one i-cache port between fetch (0) and the prefetcher (1); a flush
// kills the in-flight transaction and its response is drained silently.
// Build option: ICACHE_ARB_FIXED_PRIO_EN gives fetch fixed priority.
module icache_arbiter
  import mmm_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             flush_i,
  input  logic [NUM_IC_REQ-1:0][XLEN-1:0]  req_addr_i,
  input  logic [NUM_IC_REQ-1:0]            req_valid_i,
  output logic [NUM_IC_REQ-1:0]            req_ready_o,
  output icache_out_t                      rsp_data_o,
  output logic [NUM_IC_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_IC_REQ-1:0]            rsp_ready_i,
  output logic [XLEN-1:0]                  addr_o,
  output logic                             addr_valid_o,
  input  logic                             addr_ready_i,
  input  icache_out_t                      data_i,
  input  logic                             data_valid_i,
  output logic                             data_ready_o
);

  icache_arb_state_t       state_q, state_d;
  logic                    killed_q, killed_d;
  logic [XLEN-1:0]         addr_q, addr_d;
  logic [IC_REQ_IDX_W-1:0] owner_q, owner_d;

  logic [NUM_IC_REQ-1:0]   grant;
  logic                    grant_idx;
  logic                    grant_any;

`ifndef ICACHE_ARB_FIXED_PRIO_EN
  logic                    last_q, last_d;
`endif

  rr_arbiter_2 u_arb (
    .req_valid_i (req_valid_i),
`ifndef ICACHE_ARB_FIXED_PRIO_EN
    .last_i      (last_q),
`endif
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
      addr_q   <= '0;
      owner_q  <= '0;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign addr_o     = addr_q;
  assign rsp_data_o = data_i;

  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    addr_d       = addr_q;
    owner_d      = owner_q;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
    last_d       = last_q;
`endif
    req_ready_o  = '0;
    addr_valid_o = 1'b0;
    rsp_valid_o  = '0;
    data_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_any && !flush_i) begin
          req_ready_o = grant;
          addr_d      = req_addr_i[grant_idx];
          owner_d     = grant_idx;
`ifndef ICACHE_ARB_FIXED_PRIO_EN
          last_d      = grant_idx;
`endif
          state_d     = ADDR;
        end
      end

      ADDR: begin
        // The cache already saw this address, so a flush only marks it dead.
        addr_valid_o = 1'b1;
        if (flush_i)      killed_d = 1'b1;
        if (addr_ready_i) state_d  = WAIT;
      end

      WAIT: begin
        if (killed_q || flush_i) begin
          data_ready_o = 1'b1;
          if (data_valid_i) begin
            killed_d = 1'b0;
            state_d  = IDLE;
          end else begin
            killed_d = 1'b1;
          end
        end else begin
          rsp_valid_o[owner_q] = data_valid_i;
          data_ready_o         = rsp_ready_i[owner_q];
          if (data_valid_i && rsp_ready_i[owner_q]) state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        killed_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_arbiter.sv
// Directed bench for icache_arbiter: stimulus pushes expected grants, cache
// addresses and response beats; a monitor pops and compares on handshakes.
module tb_icache_arbiter;
  import mmm_pkg::*;

  logic                            clk;
  logic                            rst_n;
  logic                            flush;
  logic [NUM_IC_REQ-1:0][XLEN-1:0] req_addr;
  logic [NUM_IC_REQ-1:0]           req_valid;
  logic [NUM_IC_REQ-1:0]           req_ready;
  icache_out_t                     rsp_data;
  logic [NUM_IC_REQ-1:0]           rsp_valid;
  logic [NUM_IC_REQ-1:0]           rsp_ready;
  logic [XLEN-1:0]                 addr_o;
  logic                            addr_valid;
  logic                            addr_ready;
  icache_out_t                     data_in;
  logic                            data_valid;
  logic                            data_ready;

  icache_arbiter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .req_addr_i   (req_addr),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .rsp_data_o   (rsp_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .data_i       (data_in),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    icache_out_t data;
  } rsp_exp_t;

  int          exp_gnt[$];
  logic [31:0] exp_addr[$];
  rsp_exp_t    exp_rsp[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // cache model knobs and state
  int          cfg_stall = 0;
  int          cfg_delay = 0;
  int          stall_left, dly;
  logic        in_addr, pending, a_hs, d_hs;
  logic [31:0] a_val, cur_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic icache_out_t mk(input logic [31:0] a);
    icache_out_t d;
    d.instr = {a[15:0], 16'hBEEF};
    d.fault = 1'b0;
    return d;
  endfunction

  function automatic icache_out_t hand(input logic [31:0] v);
    icache_out_t d;
    d.instr = v;
    d.fault = 1'b0;
    return d;
  endfunction

  task automatic push(input int idx, input logic [31:0] a, input logic has_rsp, input logic [31:0] d);
    rsp_exp_t e;
    exp_gnt.push_back(idx);
    exp_addr.push_back(a);
    if (has_rsp) begin
      e.vld  = (idx == 0) ? 2'b01 : 2'b10;
      e.data = hand(d);
      exp_rsp.push_back(e);
    end
  endtask

  // Zero-wait transaction starting in an IDLE cycle.
  task automatic simple_txn(input logic [1:0] rv, input int idx, input logic [31:0] a,
                            input logic [31:0] d);
    logic [1:0] oh;
    oh = (idx == 0) ? 2'b01 : 2'b10;
    req_valid     = rv;
    req_addr[idx] = a;
    push(idx, a, 1'b1, d);
    #1 chk("txn_req_ready", req_ready, oh);
    tick();
    req_valid = 2'b00;
    #1 chk("txn_addr_valid", addr_valid, 1);
    chk("txn_addr", addr_o, a);
    tick();
    #1 chk("txn_rsp_valid", rsp_valid, oh);
    tick();
    #1 chk("txn_idle_addr_valid", addr_valid, 0);
    chk("txn_idle_data_ready", data_ready, 0);
  endtask

  // i-cache model: accepts after cfg_stall cycles, answers cfg_delay cycles later
  initial begin
    addr_ready = 1'b0; data_valid = 1'b0; data_in = '0;
    in_addr = 1'b0; pending = 1'b0; stall_left = 0; dly = 0; cur_addr = '0;
    forever begin
      @(negedge clk);
      a_hs  = addr_valid && addr_ready;
      a_val = addr_o;
      d_hs  = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending = 1'b0; in_addr = 1'b0; addr_ready = 1'b0; data_valid = 1'b0;
      end else begin
        if (d_hs) begin pending = 1'b0; data_valid = 1'b0; end
        if (a_hs) begin pending = 1'b1; cur_addr = a_val; dly = cfg_delay; end
        if (pending && !data_valid) begin
          if (dly == 0) begin data_valid = 1'b1; data_in = mk(cur_addr); end
          else dly--;
        end
        if (addr_valid) begin
          if (!in_addr) begin in_addr = 1'b1; stall_left = cfg_stall; end
          if (stall_left > 0) begin addr_ready = 1'b0; stall_left--; end
          else addr_ready = 1'b1;
        end else begin
          in_addr = 1'b0; addr_ready = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NUM_IC_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            if (exp_gnt.size() == 0) unexpected("sb_gnt", i);
            else chk("sb_gnt", i, exp_gnt.pop_front());
          end
        end
        if (addr_valid && addr_ready) begin
          if (exp_addr.size() == 0) unexpected("sb_addr", addr_o);
          else chk("sb_addr", addr_o, exp_addr.pop_front());
        end
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (exp_rsp.size() == 0) unexpected("sb_rsp", rsp_valid);
          else begin
            e = exp_rsp.pop_front();
            chk("sb_rsp_valid", rsp_valid, e.vld);
            chk("sb_rsp_data", rsp_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[4];
`ifdef ICACHE_ARB_FIXED_PRIO_EN
    tbl = '{0, 0, 0, 0};
`else
    // requester 0 won the preceding single transaction, so 1 goes first
    tbl = '{1, 0, 1, 0};
`endif
    rst_n = 1'b0; flush = 1'b0; req_valid = 2'b00; req_addr = '0; rsp_ready = 2'b11;
    #3;
    chk("rst_addr_valid", addr_valid, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single request
    simple_txn(2'b01, 0, 32'h1000, 32'h1000BEEF);

    // contention
    for (int k = 0; k < 4; k++) begin
      req_valid   = 2'b11;
      req_addr[0] = 32'h100;
      req_addr[1] = 32'h200;
      push(tbl[k], (tbl[k] == 1) ? 32'h200 : 32'h100, 1'b1,
           (tbl[k] == 1) ? 32'h0200BEEF : 32'h0100BEEF);
      #1 chk("cont_req_ready", req_ready, (tbl[k] == 1) ? 2'b10 : 2'b01);
      tick(); tick(); tick();
    end
    req_valid = 2'b00;

    // cache stall in ADDR, requester keeps asking
    cfg_stall   = 4;
    req_valid   = 2'b10;
    req_addr[1] = 32'h2468;
    push(1, 32'h2468, 1'b1, 32'h2468BEEF);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1 chk("stall_addr_valid", addr_valid, 1);
      chk("stall_addr", addr_o, 32'h2468);
      chk("stall_req_ready", req_ready, 0);
      tick();
    end
    cfg_stall = 0;
    tick();
    req_valid = 2'b00;
    #1 chk("stall_rsp_valid", rsp_valid, 2'b10);
    tick();

    // flush in WAIT, response three cycles later
    cfg_delay   = 3;
    req_valid   = 2'b01;
    req_addr[0] = 32'h3000;
    push(0, 32'h3000, 1'b0, 32'h0);
    tick();
    req_valid = 2'b00;
    tick();
    flush = 1'b1;
    #1 chk("kill_w0_data_ready", data_ready, 1);
    chk("kill_w0_rsp_valid", rsp_valid, 0);
    tick();
    flush = 1'b0;
    #1 chk("kill_w1_data_ready", data_ready, 1);
    tick(); tick();
    #1 chk("kill_beat_valid_in", data_valid, 1);
    chk("kill_beat_data_ready", data_ready, 1);
    chk("kill_beat_rsp_valid", rsp_valid, 0);
    tick();
    #1 chk("kill_idle_addr_valid", addr_valid, 0);
    chk("kill_idle_data_ready", data_ready, 0);
    cfg_delay = 0;
    simple_txn(2'b01, 0, 32'h3004, 32'h3004BEEF);

    // flush coincident with the response beat, then flush in IDLE
    cfg_delay   = 1;
    req_valid   = 2'b10;
    req_addr[1] = 32'h4000;
    push(1, 32'h4000, 1'b0, 32'h0);
    tick();
    req_valid = 2'b00;
    tick();
    #1 chk("coinc_w0_data_ready", data_ready, 1);
    chk("coinc_w0_rsp_valid", rsp_valid, 0);
    tick();
    flush = 1'b1;
    #1 chk("coinc_beat_rsp_valid", rsp_valid, 0);
    chk("coinc_beat_data_ready", data_ready, 1);
    tick();
    req_valid   = 2'b11;
    req_addr[0] = 32'h4100;
    req_addr[1] = 32'h4200;
    #1 chk("flush_idle_req_ready", req_ready, 0);
    chk("coinc_idle_data_ready", data_ready, 0);
    tick();
    flush = 1'b0;
    req_valid = 2'b00;
    #1 chk("flush_idle_no_grant", addr_valid, 0);
    cfg_delay = 5;

    // asynchronous reset mid-WAIT
    req_valid   = 2'b01;
    req_addr[0] = 32'h5000;
    push(0, 32'h5000, 1'b0, 32'h0);
    tick();
    req_valid = 2'b00;
    tick();
    #1 rst_n = 1'b0;
    #1 chk("arst_addr_valid", addr_valid, 0);
    chk("arst_addr", addr_o, 0);
    chk("arst_data_ready", data_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    tick();
    cfg_delay = 0;
    rst_n = 1'b1;
    req_addr[1] = 32'h700;
    simple_txn(2'b11, 0, 32'h600, 32'h0600BEEF);

    repeat (2) tick();
    chk("sb_gnt_drained", exp_gnt.size(), 0);
    chk("sb_addr_drained", exp_addr.size(), 0);
    chk("sb_rsp_drained", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
